muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit implementing the RV32M funct3 set (MUL..REMU), parametrised in WIDTH.

---
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (MUL..REMU), one bit per clock, WIDTH parameterised.
// Latency: done pulses WIDTH+1 edges after the accept edge (1 edge on early-out when MULDIV_EARLY_OUT_EN is defined).
// Backpressure: none; start is only accepted in IDLE, ignored while busy, never queued.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       op;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    // Multiplicand (multiply) or divisor (divide), as a magnitude
    logic [WIDTH-1:0] opnd;
    // Multiply: high half of product. Divide: partial remainder (always < divisor, so WIDTH bits hold it).
    logic [WIDTH-1:0] acc;
    // Multiply: multiplier shifting out / product low half. Divide: dividend shifting out / quotient shifting in.
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;

    logic             a_sgn_in;
    logic             b_sgn_in;
    logic             a_neg_in;
    logic             b_neg_in;
    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;
    logic             early;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_next;

    // Operand signedness and magnitudes for the request being offered
    always_comb begin
        a_sgn_in = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        b_sgn_in = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg_in = a_sgn_in & operand_a[WIDTH-1];
        b_neg_in = b_sgn_in & operand_b[WIDTH-1];
        a_mag_in = a_neg_in ? -operand_a : operand_a;
        b_mag_in = b_neg_in ? -operand_b : operand_b;
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Zero divisor, or a zero operand on a multiply, has a result known at accept time
    assign early = (operand_b == '0) || ((operand_a == '0) && !funct3[2]);
`else
    assign early = 1'b0;
`endif

    // One iteration step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_shift = {acc, lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
    end

    // Sign correction and result selection. The most-negative / -1 divide
    // needs no special case: magnitude 2^(WIDTH-1) negated wraps back to itself
    // and the remainder is zero. Divide-by-zero leaves the remainder equal to the
    // dividend magnitude, so only the quotient is forced.
    always_comb begin
        prod_fix = (a_neg ^ b_neg) ? -{acc, lo} : {acc, lo};
        quo_fix  = (a_neg ^ b_neg) ? -lo : lo;
        rem_fix  = a_neg ? -acc : acc;
        res_next = '0;
        case (op)
            3'b000:                 res_next = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: res_next = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         res_next = b_zero ? {WIDTH{1'b1}} : quo_fix;
            default:                res_next = rem_fix;
        endcase
    end

    // Control FSM and datapath registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= IDLE;
            op     <= '0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            b_zero <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            lo     <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op     <= funct3;
                        a_neg  <= a_neg_in;
                        b_neg  <= b_neg_in;
                        b_zero <= (operand_b == '0);
                        cnt    <= '0;
                        busy   <= 1'b1;
                        if (early) begin
                            // Remainder path must still see the dividend; products are zero
                            state <= FINISH;
                            opnd  <= b_mag_in;
                            acc   <= funct3[2] ? a_mag_in : '0;
                            lo    <= '0;
                        end else begin
                            state <= RUN;
                            opnd  <= funct3[2] ? b_mag_in : a_mag_in;
                            lo    <= funct3[2] ? a_mag_in : b_mag_in;
                            acc   <= '0;
                        end
                    end
                end
                RUN: begin
                    if (op[2]) begin
                        if (!div_diff[WIDTH]) begin
                            acc <= div_diff[WIDTH-1:0];
                            lo  <= {lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= div_shift[WIDTH-1:0];
                            lo  <= {lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        lo  <= {mul_sum[0], lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    result <= res_next;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit at WIDTH=32: directed vector table, multi-cycle sequences, random ops vs reference model.
// Latency: checks done arrives exactly 33 edges after accept (1 on early-out builds).
// Backpressure: exercises ignored start while busy and back-to-back start on the done cycle.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // RV32M semantics from plain integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (f)
            3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'b010: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return sa / sb;
            end
            3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (b == 0 || (a == 0 && !f[2])) return 1;
`endif
        return 33;
    endfunction

    // Issue one op; returns at done cycle (+1ns) so a caller may start again immediately.
    // inj>0 pulses a competing start on that cycle of the running op.
    task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int inj, output logic [31:0] res, output int lat);
        funct3    = f;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start     = 1'b0;
        funct3    = 3'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
        chk({nm, "_busy_at_accept"}, 32'(busy), 32'd1);
        lat = -1;
        res = 'x;
        for (int c = 1; c <= 100 && lat < 0; c++) begin
            @(posedge clock);
            #1;
            if (done) begin
                lat = c;
                res = result;
                chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
            end else if (c == inj) begin
                start     = 1'b1;
                funct3    = 3'b100;
                operand_a = 32'd100;
                operand_b = 32'd7;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat(f, a, b)));
    endtask

    logic [31:0] res;
    logic [31:0] held;
    int          lat;
    logic        saw_done;

    initial begin
        tbl[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
        tbl[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000};
        tbl[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        tbl[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tbl[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        tbl[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        tbl[6]  = '{3'b101, 32'd100,      32'd7,        32'd14};
        tbl[7]  = '{3'b111, 32'd100,      32'd7,        32'd2};
        tbl[8]  = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF};
        tbl[9]  = '{3'b110, 32'd5,        32'd0,        32'd5};
        tbl[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        tbl[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0};
        tbl[12] = '{3'b101, 32'd9,        32'd0,        32'hFFFFFFFF};
        tbl[13] = '{3'b101, 32'd9,        32'd3,        32'd3};
        tbl[14] = '{3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF};
        tbl[15] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};

        reset_n   = 1'b0;
        start     = 1'b0;
        funct3    = 3'b000;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_busy",   32'(busy), 32'd0);
        chk("reset_done",   32'(done), 32'd0);
        chk("reset_result", result,    32'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Directed vectors
        for (int i = 0; i < 16; i++) begin
            do_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, 0, res, lat);
            chk($sformatf("vec%0d_result", i), res, tbl[i].exp);
        end

        // done is one cycle wide and result is held afterwards
        do_op("width", 3'b000, 32'd7, 32'hFFFFFFFD, 0, res, lat);
        held = res;
        @(posedge clock);
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("result_held",    result,    held);

        // start pulsed mid-operation is ignored
        do_op("ignore", 3'b000, 32'd7, 32'hFFFFFFFD, 10, res, lat);
        chk("ignore_result", res, 32'hFFFFFFEB);
        repeat (40) @(posedge clock);
        #1;
        chk("ignore_no_extra_done", 32'(busy), 32'd0);

        // start on the done cycle is accepted; second op completes 33 edges later
        do_op("b2b_first", 3'b101, 32'd100, 32'd7, 0, res, lat);
        chk("b2b_first_result", res, 32'd14);
        do_op("b2b_second", 3'b111, 32'd100, 32'd7, 0, res, lat);
        chk("b2b_second_result", res, 32'd2);

        // reset at cycle 20 of a running op aborts it
        funct3    = 3'b011;
        operand_a = 32'hFFFFFFFF;
        operand_b = 32'hFFFFFFFF;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        chk("midreset_busy",   32'(busy), 32'd0);
        chk("midreset_done",   32'(done), 32'd0);
        chk("midreset_result", result,    32'd0);
        reset_n  = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (done) saw_done = 1'b1;
        end
        chk("midreset_no_done", 32'(saw_done), 32'd0);

        // Random ops biased toward corner operands
        for (int i = 0; i < 150; i++) begin
            logic [2:0]  f;
            logic [31:0] a;
            logic [31:0] b;
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: a = 32'd0;
                1: a = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: a = 32'($urandom_range(0, 20));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'h80000000;
                3: b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            do_op($sformatf("rnd%0d", i), f, a, b, 0, res, lat);
            chk($sformatf("rnd%0d_f%0d_%h_%h", i, f, a, b), res, ref_model(f, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
